// File: rtl/regfile_pkg.sv
// Shared widths and enums for the register-file write-port arbiter and its clear sequencer.
package regfile_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned DATA_W    = 32;

  typedef enum logic {
    StIdle,
    StClear
  } clr_state_e;

  typedef enum logic [1:0] {
    GntNone,
    GntWb,
    GntMd,
    GntSweep
  } gnt_src_e;

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: on clr_start_i, sweeps index 1..NUM_REGS-1, issuing one zero-write per cycle.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_start_i,
  output logic                 busy_o,
  output logic [REG_IDX_W-1:0] idx_o
);

  localparam logic [REG_IDX_W-1:0] LastIdx = REG_IDX_W'(NUM_REGS - 1);

  clr_state_e           state_q;
  logic                 busy_q;
  logic [REG_IDX_W-1:0] idx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (clr_start_i) begin
            state_q <= StClear;
            busy_q  <= 1'b1;
            idx_q   <= REG_IDX_W'(1);
          end
        end
        StClear: begin
          // idx_q is the index being issued this cycle; leave once the last one goes out.
          if (idx_q == LastIdx) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + REG_IDX_W'(1);
          end
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign idx_o  = idx_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: sweep > (starved mult/div) > writeback > mult/div.
// Optional starvation override enabled by defining REGFILE_ARB_STARVE_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned NUM_REGS     = 32
) (
  input  logic                 clock,
  input  logic                 ctrl_reset_n,
  input  logic                 clr_start,
  output logic                 clr_busy,
  input  logic                 wb_valid,
  output logic                 wb_ready,
  input  logic [REG_IDX_W-1:0] wb_reg,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic                 md_valid,
  output logic                 md_ready,
  input  logic [REG_IDX_W-1:0] md_reg,
  input  logic [DATA_W-1:0]    md_data,
  output logic                 rf_writeEn,
  output logic [REG_IDX_W-1:0] rf_writeReg,
  output logic [DATA_W-1:0]    rf_writeData
);

  logic                 sweep_busy;
  logic [REG_IDX_W-1:0] sweep_idx;
  logic                 starve_hit;
  gnt_src_e             gnt_src;

  regfile_clr_seq #(
    .NUM_REGS(NUM_REGS)
  ) u_clr_seq (
    .clk_i      (clock),
    .rst_ni     (ctrl_reset_n),
    .clr_start_i(clr_start),
    .busy_o     (sweep_busy),
    .idx_o      (sweep_idx)
  );

  assign clr_busy = sweep_busy;

`ifdef REGFILE_ARB_STARVE_EN
  logic [3:0] starve_d, starve_q;

  assign starve_hit = (starve_q == 4'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    // Counter is frozen for the whole sweep so a pending md request keeps its credit.
    if (!sweep_busy) begin
      if (!md_valid || md_ready) begin
        starve_d = '0;
      end else if (!starve_hit) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  // Readies are forced low while reset is held so no grant is visible during reset.
  always_comb begin
    gnt_src = GntNone;
    if (!ctrl_reset_n) begin
      gnt_src = GntNone;
    end else if (sweep_busy) begin
      gnt_src = GntSweep;
    end else if (md_valid && starve_hit) begin
      gnt_src = GntMd;
    end else if (wb_valid) begin
      gnt_src = GntWb;
    end else if (md_valid) begin
      gnt_src = GntMd;
    end
  end

  assign wb_ready = (gnt_src == GntWb);
  assign md_ready = (gnt_src == GntMd);

  logic                 we_d, we_q;
  logic [REG_IDX_W-1:0] reg_d, reg_q;
  logic [DATA_W-1:0]    data_d, data_q;

  always_comb begin
    we_d   = 1'b0;
    reg_d  = reg_q;
    data_d = data_q;
    case (gnt_src)
      GntSweep: begin
        we_d   = 1'b1;
        reg_d  = sweep_idx;
        data_d = '0;
      end
      GntWb: begin
        we_d   = (wb_reg != '0);
        reg_d  = wb_reg;
        data_d = wb_data;
      end
      GntMd: begin
        we_d   = (md_reg != '0);
        reg_d  = md_reg;
        data_d = md_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      we_q   <= 1'b0;
      reg_q  <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      reg_q  <= reg_d;
      data_q <= data_d;
    end
  end

  assign rf_writeEn   = we_q;
  assign rf_writeReg  = reg_q;
  assign rf_writeData = data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, priority, r0 drop, clear sweep, reset mid-sweep.
module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        ctrl_reset_n;
  logic        clr_start;
  logic        clr_busy;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        rf_writeEn;
  logic [4:0]  rf_writeReg;
  logic [31:0] rf_writeData;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(
    .STARVE_LIMIT(4),
    .NUM_REGS    (32)
  ) dut (
    .clock       (clock),
    .ctrl_reset_n(ctrl_reset_n),
    .clr_start   (clr_start),
    .clr_busy    (clr_busy),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_reg      (wb_reg),
    .wb_data     (wb_data),
    .md_valid    (md_valid),
    .md_ready    (md_ready),
    .md_reg      (md_reg),
    .md_data     (md_data),
    .rf_writeEn  (rf_writeEn),
    .rf_writeReg (rf_writeReg),
    .rf_writeData(rf_writeData)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_out(input string tag, input logic en, input logic [4:0] r,
                           input logic [31:0] d);
    check({tag, "_en"}, {31'd0, rf_writeEn}, {31'd0, en});
    check({tag, "_reg"}, {27'd0, rf_writeReg}, {27'd0, r});
    check({tag, "_data"}, rf_writeData, d);
  endtask

  initial begin
    bit starve_en;
    bit exp_md;
`ifdef REGFILE_ARB_STARVE_EN
    starve_en = 1'b1;
`else
    starve_en = 1'b0;
`endif
    ctrl_reset_n = 1'b1;
    clr_start    = 1'b0;
    wb_valid     = 1'b1;
    wb_reg       = 5'd3;
    wb_data      = 32'h1111_1111;
    md_valid     = 1'b1;
    md_reg       = 5'd4;
    md_data      = 32'h2222_2222;
    #1 ctrl_reset_n = 1'b0;

    // Reset held with both requesters valid.
    tick();
    tick();
    check_out("rst", 1'b0, 5'd0, 32'd0);
    check("rst_wb_ready", {31'd0, wb_ready}, 32'd0);
    check("rst_md_ready", {31'd0, md_ready}, 32'd0);
    check("rst_busy", {31'd0, clr_busy}, 32'd0);

    // First writeback after release.
    md_valid     = 1'b0;
    wb_reg       = 5'd5;
    wb_data      = 32'hDEAD_BEEF;
    ctrl_reset_n = 1'b1;
    #1 check("rel_wb_ready", {31'd0, wb_ready}, 32'd1);
    tick();
    wb_valid = 1'b0;
    check_out("rel_wr", 1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    check_out("idle_hold", 1'b0, 5'd5, 32'hDEAD_BEEF);

    // Lone mult/div request.
    md_valid = 1'b1;
    md_reg   = 5'd12;
    md_data  = 32'h0000_1234;
    #1 check("md_only_ready", {31'd0, md_ready}, 32'd1);
    tick();
    md_valid = 1'b0;
    check_out("md_only_wr", 1'b1, 5'd12, 32'h0000_1234);

    // Contention: writeback wins unless the starvation override fires on the 5th cycle.
    wb_valid = 1'b1;
    wb_reg   = 5'd6;
    wb_data  = 32'h0000_0011;
    md_valid = 1'b1;
    md_reg   = 5'd7;
    md_data  = 32'h0000_0022;
    for (int i = 0; i < 8; i++) begin
      exp_md = starve_en && (i == 4);
      #1;
      check($sformatf("cont%0d_wb_ready", i), {31'd0, wb_ready}, {31'd0, !exp_md});
      check($sformatf("cont%0d_md_ready", i), {31'd0, md_ready}, {31'd0, exp_md});
      tick();
      check_out($sformatf("cont%0d", i), 1'b1, exp_md ? 5'd7 : 5'd6,
                exp_md ? 32'h22 : 32'h11);
    end

    // Request to r0 is accepted but writes nothing.
    wb_valid = 1'b0;
    md_reg   = 5'd0;
    md_data  = 32'd7;
    #1 check("r0_md_ready", {31'd0, md_ready}, 32'd1);
    tick();
    md_valid = 1'b0;
    check_out("r0_wr", 1'b0, 5'd0, 32'd7);
    tick();

    // Clear sweep started together with a writeback request.
    clr_start = 1'b1;
    wb_valid  = 1'b1;
    wb_reg    = 5'd9;
    wb_data   = 32'h0000_0099;
    #1 check("sw_start_wb_ready", {31'd0, wb_ready}, 32'd1);
    tick();
    clr_start = 1'b0;
    wb_reg    = 5'd10;
    wb_data   = 32'h0000_00AA;
    check_out("sw_start_wr", 1'b1, 5'd9, 32'h99);
    for (int k = 1; k < 32; k++) begin
      #1;
      check($sformatf("sw%0d_busy", k), {31'd0, clr_busy}, 32'd1);
      check($sformatf("sw%0d_wb_ready", k), {31'd0, wb_ready}, 32'd0);
      tick();
      check_out($sformatf("sw%0d", k), 1'b1, 5'(k), 32'd0);
    end
    check("sw_end_busy", {31'd0, clr_busy}, 32'd0);
    check("sw_end_wb_ready", {31'd0, wb_ready}, 32'd1);
    tick();
    wb_valid = 1'b0;
    check_out("sw_after_wr", 1'b1, 5'd10, 32'hAA);
    tick();

    // Reset while the sweep is issuing index 10.
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    check_out("pre_abort", 1'b1, 5'd9, 32'd0);
    ctrl_reset_n = 1'b0;
    #1;
    check_out("abort", 1'b0, 5'd0, 32'd0);
    check("abort_busy", {31'd0, clr_busy}, 32'd0);
    tick();
    ctrl_reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("post_abort%0d_en", k), {31'd0, rf_writeEn}, 32'd0);
      check($sformatf("post_abort%0d_busy", k), {31'd0, clr_busy}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
